// File: rtl/pr_chk_pkg.sv
// Shared types and helpers for the PR loopback checker.
//   state_t    : checker FSM states
//   LFSR_MASK  : Galois mask for x^32+x^22+x^2+x+1 (right-shifting form)
//   DEF_MARKER : default alignment word
//   lfsr_next  : one step of the payload LFSR
package pr_chk_pkg;

  typedef enum logic [1:0] {IDLE, ALIGN, RUN, DONE} state_t;

  localparam logic [31:0] LFSR_MASK  = 32'h8020_0003;
  localparam logic [31:0] DEF_MARKER = 32'hA5A5_0001;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/pr_lfsr32.sv
// 32-bit Galois LFSR word generator.
//   clock, reset : reset is synchronous, active-high, and loads seed
//   load         : reload seed (takes priority over advance)
//   seed         : value loaded on reset/load
//   advance      : step to the next word
//   value        : current word
module pr_lfsr32
  import pr_chk_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] value
);

  always_ff @(posedge clock) begin
    if (reset || load) value <= seed;
    else if (advance)  value <= lfsr_next(value);
  end

endmodule

// File: rtl/pr_loopback_checker.sv
// Drives a marker then an LFSR payload into a reconfigurable partition's
// loopback lane and checks what comes back.
//   clock, reset      : shared clock; synchronous active-high reset
//   start             : one-cycle pulse, accepted in IDLE/DONE when not decoupled
//   decouple          : PR decouple; aborts an active run, blocks start
//   to_pr / from_pr   : lane out (registered) / lane return
//   busy, done, pass  : status; pass qualified by done
//   timeout, aborted  : sticky failure causes, cleared on next start
//   latency           : measured round-trip latency in cycles
//   err_count         : mismatching payload words, saturating
module pr_loopback_checker
  import pr_chk_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 256,
  parameter int unsigned MAX_LAT   = 15,
  parameter logic [31:0] SEED      = 32'h0000_0001,
  parameter logic [31:0] MARKER    = DEF_MARKER
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        decouple,
  output logic [31:0] to_pr,
  input  logic [31:0] from_pr,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic        aborted,
  output logic [3:0]  latency,
  output logic [15:0] err_count
);

  state_t       state, state_nxt;
  logic [3:0]   c;
  logic [15:0]  sent, rcvd;
  logic [MAX_LAT:0] vld_pipe;   // [0] = to_pr holds a payload word this cycle
  logic [31:0]  tx_val, exp_val;
  logic         accept, hit, tmo, abort, launch, cmp, arrive;

  // Arrival tap: the launch-valid delayed by the measured latency.
  always_comb begin
    arrive = 1'b0;
    for (int i = 0; i <= int'(MAX_LAT); i++)
      if (latency == 4'(i)) arrive = vld_pipe[i];
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    hit       = 1'b0;
    tmo       = 1'b0;
    abort     = 1'b0;
    launch    = 1'b0;
    cmp       = 1'b0;
    case (state)
      IDLE, DONE: if (start && !decouple) begin
        accept    = 1'b1;
        state_nxt = ALIGN;
      end
      ALIGN: begin
        if (decouple) begin
          abort     = 1'b1;
          state_nxt = DONE;
        end else if (from_pr == MARKER) begin
          // Match wins over timeout at c == MAX_LAT.
          hit       = 1'b1;
          launch    = 1'b1;
          state_nxt = RUN;
        end else if (c == 4'(MAX_LAT)) begin
          tmo       = 1'b1;
          state_nxt = DONE;
        end
      end
      RUN: begin
        if (decouple) begin
          // Decouple wins over a final arrival in the same cycle.
          abort     = 1'b1;
          state_nxt = DONE;
        end else begin
          launch = (sent < 16'(NUM_WORDS));
          cmp    = arrive;
          if (arrive && rcvd == 16'(NUM_WORDS - 1)) state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      to_pr     <= '0;
      c         <= '0;
      latency   <= '0;
      err_count <= '0;
      timeout   <= 1'b0;
      aborted   <= 1'b0;
      sent      <= '0;
      rcvd      <= '0;
      vld_pipe  <= '0;
    end else if (accept) begin
      to_pr     <= MARKER;
      c         <= '0;
      latency   <= '0;
      err_count <= '0;
      timeout   <= 1'b0;
      aborted   <= 1'b0;
      sent      <= '0;
      rcvd      <= '0;
      vld_pipe  <= '0;
    end else begin
      to_pr       <= launch ? tx_val : 32'h0;
      vld_pipe[0] <= launch;
      for (int i = 1; i <= int'(MAX_LAT); i++) vld_pipe[i] <= vld_pipe[i-1];
      if (state == ALIGN) c <= c + 4'd1;
      if (hit)    latency <= c;
      if (tmo)    timeout <= 1'b1;
      if (abort)  aborted <= 1'b1;
      if (launch) sent    <= sent + 16'd1;
      if (cmp) begin
        rcvd <= rcvd + 16'd1;
        if (from_pr != exp_val && err_count != 16'hFFFF)
          err_count <= err_count + 16'd1;
      end
    end
  end

  pr_lfsr32 u_tx (
    .clock(clock), .reset(reset), .load(accept), .seed(SEED),
    .advance(launch), .value(tx_val)
  );

  pr_lfsr32 u_exp (
    .clock(clock), .reset(reset), .load(accept), .seed(SEED),
    .advance(cmp), .value(exp_val)
  );

  assign busy = (state == ALIGN) || (state == RUN);
  assign done = (state == DONE);
  assign pass = done && (err_count == 16'h0) && !timeout && !aborted;

endmodule

// File: tb/tb_pr_loopback_checker.sv
module tb_pr_loopback_checker;

  localparam int          NW = 16;
  localparam int          ML = 15;
  localparam logic [31:0] MK = 32'hA5A5_0001;
  localparam logic [31:0] SD = 32'h0000_0001;

  logic        clock = 1'b0;
  logic        reset, start, decouple;
  logic [31:0] to_pr, from_pr;
  logic        busy, done, pass, timeout, aborted;
  logic [3:0]  latency;
  logic [15:0] err_count;

  int nchk = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  pr_loopback_checker #(.NUM_WORDS(NW), .MAX_LAT(ML), .SEED(SD), .MARKER(MK)) dut (
    .clock(clock), .reset(reset), .start(start), .decouple(decouple),
    .to_pr(to_pr), .from_pr(from_pr), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .aborted(aborted), .latency(latency), .err_count(err_count)
  );

  // Behavioural RP: d-cycle delay (0 = wire), optional tie-to-zero, and up to
  // two payload words corrupted by value.
  int          dly = 1;
  bit          tie0 = 1'b0;
  logic [31:0] pipe [16];
  logic [31:0] raw;
  logic [31:0] cval [2];
  logic [31:0] cmask[2];
  logic [31:0] words[NW];
  logic [31:0] rec  [100];

  always @(posedge clock) begin
    pipe[0] <= to_pr;
    for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
  end

  always_comb begin
    raw     = (dly == 0) ? to_pr : pipe[dly-1];
    from_pr = raw;
    for (int j = 0; j < 2; j++)
      if (cmask[j] != 32'h0 && raw == cval[j]) from_pr = raw ^ cmask[j];
    if (tie0) from_pr = 32'h0;
  end

  // Payload sequence: seed first, then x^32+x^22+x^2+x+1 Galois steps.
  function automatic logic [31:0] poly_step(input logic [31:0] v);
    logic fb;
    fb = v[0];
    v  = v >> 1;
    if (fb) v = v ^ ((32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, ".to_pr"},   to_pr,     0);
    chk({tag, ".busy"},    busy,      0);
    chk({tag, ".done"},    done,      0);
    chk({tag, ".pass"},    pass,      0);
    chk({tag, ".timeout"}, timeout,   0);
    chk({tag, ".aborted"}, aborted,   0);
    chk({tag, ".latency"}, latency,   0);
    chk({tag, ".errcnt"},  err_count, 0);
  endtask

  // One run: d = loopback delay, t0 = RP output tied low, ncor = corrupted
  // words, dec_at = busy-cycle index at which decouple is pulsed (-1 = none).
  task automatic run(input string tag, input int d, input bit t0, input int ncor, input int dec_at);
    int n, e_n, e_err, bad, nw;
    bit e_tmo, e_abt, e_pass;
    dly = d; tie0 = t0;
    cmask[0] = 32'h0; cmask[1] = 32'h0;
    if (ncor >= 1) begin cval[0] = words[2]; cmask[0] = 32'h80; end
    if (ncor >= 2) begin
      cval[1]  = words[$urandom_range(NW-1, 3)];
      cmask[1] = 32'h1 << $urandom_range(31, 0);
    end
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      rec[n]   = to_pr;
      start    = (n == 3);          // start while busy must be ignored
      decouple = (n == dec_at);
      @(negedge clock);
      n++;
    end
    start = 1'b0; decouple = 1'b0;

    e_tmo = 0; e_abt = 0; e_err = 0;
    if (t0) begin
      e_n = ML + 1; e_tmo = 1;
    end else if (dec_at >= 0) begin
      e_n = dec_at + 1; e_abt = 1;
    end else begin
      e_n = 2*d + NW + 1; e_err = ncor;
    end
    e_pass = !e_tmo && !e_abt && (e_err == 0);

    chk({tag, ".cycles"},  n,         e_n);
    chk({tag, ".done"},    done,      1);
    chk({tag, ".busy"},    busy,      0);
    chk({tag, ".latency"}, latency,   t0 ? 0 : d);
    chk({tag, ".errcnt"},  err_count, e_err);
    chk({tag, ".timeout"}, timeout,   e_tmo);
    chk({tag, ".aborted"}, aborted,   e_abt);
    chk({tag, ".pass"},    pass,      e_pass);
    chk({tag, ".to_pr"},   to_pr,     0);
    chk({tag, ".marker"},  rec[0],    MK);

    bad = 0;
    if (t0) begin
      for (int i = 1; i < n && i < 100; i++) if (rec[i] !== 32'h0) bad++;
    end else begin
      nw = (dec_at >= 0) ? dec_at - d : NW;
      for (int k = 0; k < nw; k++) if (rec[d+1+k] !== words[k]) bad++;
    end
    chk({tag, ".txseq"}, bad, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; decouple = 1'b0;
    cmask[0] = 32'h0; cmask[1] = 32'h0; cval[0] = 32'h0; cval[1] = 32'h0;
    words[0] = SD;
    for (int k = 1; k < NW; k++) words[k] = poly_step(words[k-1]);

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_quiet("rst");

    run("reg1",  1, 0, 0, -1);
    run("wire",  0, 0, 0, -1);
    run("dly5",  5, 0, 0, -1);
    run("flip1", 5, 0, 1, -1);
    run("flip2", 5, 0, 2, -1);
    run("tmo",   3, 1, 0, -1);
    run("dec",   2, 0, 0, 2 + 8);

    // start while decoupled must leave the block in DONE
    @(negedge clock); decouple = 1'b1; start = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock); decouple = 1'b0;
    chk("decstart.done",    done,    1);
    chk("decstart.busy",    busy,    0);
    chk("decstart.aborted", aborted, 1);

    // reset in the middle of RUN
    dly = 1; tie0 = 0; cmask[0] = 32'h0; cmask[1] = 32'h0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (10) @(negedge clock);
    chk("midrun.busy", busy, 1);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_quiet("midrst");
    run("after", 1, 0, 0, -1);

    for (int r = 0; r < 4; r++)
      run($sformatf("rnd%0d", r), $urandom_range(7, 0), 0, $urandom_range(2, 0), -1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
